// File: rtl/fc_seq_classifier.sv
// fc_seq_classifier: time-multiplexed fully-connected layer with argmax.
// One signed MAC walks N_OUT neurons over N_IN inputs read from external
// synchronous RAMs (1-cycle latency). Each neuron result is streamed out
// and the index of the largest result is reported at job end.
// Optional build macro: RELU_EN (clamp each neuron result to >= 0).
module fc_seq_classifier #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned N_IN   = 120,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned ACC_W  = 40,
  localparam int unsigned XA_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned BA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  output logic [XA_W-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [BA_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              y_valid,
  output logic [BA_W-1:0]   y_idx,
  output logic [DATA_W-1:0] y_data,
  output logic              done,
  output logic [BA_W-1:0]   classified,
  output logic [DATA_W-1:0] max_score
);

  localparam int unsigned P_W  = 2 * DATA_W;
  localparam int unsigned HI_W = ACC_W - DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state, state_n;
  logic [XA_W-1:0]           k, k_n;
  logic [BA_W-1:0]           j, j_n;
  logic signed [ACC_W-1:0]   acc, acc_n;
  logic [BA_W-1:0]           cand_idx, cand_idx_n;
  logic signed [DATA_W-1:0]  cand_val, cand_val_n;

  logic [XA_W-1:0]           x_addr_n;
  logic [WA_W-1:0]           w_addr_n;
  logic [BA_W-1:0]           b_addr_n;
  logic                      busy_n, y_valid_n, done_n;
  logic [BA_W-1:0]           y_idx_n, classified_n;
  logic [DATA_W-1:0]         y_data_n, max_score_n;

  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   shifted;
  logic [HI_W-1:0]           hi;
  logic signed [DATA_W-1:0]  res;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= IDLE;
      k          <= '0;
      j          <= '0;
      acc        <= '0;
      cand_idx   <= '0;
      cand_val   <= '0;
      x_addr     <= '0;
      w_addr     <= '0;
      b_addr     <= '0;
      busy       <= 1'b0;
      y_valid    <= 1'b0;
      y_idx      <= '0;
      y_data     <= '0;
      done       <= 1'b0;
      classified <= '0;
      max_score  <= '0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      j          <= j_n;
      acc        <= acc_n;
      cand_idx   <= cand_idx_n;
      cand_val   <= cand_val_n;
      x_addr     <= x_addr_n;
      w_addr     <= w_addr_n;
      b_addr     <= b_addr_n;
      busy       <= busy_n;
      y_valid    <= y_valid_n;
      y_idx      <= y_idx_n;
      y_data     <= y_data_n;
      done       <= done_n;
      classified <= classified_n;
      max_score  <= max_score_n;
    end
  end

  // Next-state, MAC, rounding/saturation and argmax update
  always_comb begin
    state_n      = state;
    k_n          = k;
    j_n          = j;
    acc_n        = acc;
    cand_idx_n   = cand_idx;
    cand_val_n   = cand_val;
    x_addr_n     = x_addr;
    w_addr_n     = w_addr;
    b_addr_n     = b_addr;
    y_valid_n    = 1'b0;
    y_idx_n      = y_idx;
    y_data_n     = y_data;
    done_n       = 1'b0;
    classified_n = classified;
    max_score_n  = max_score;

    // Full-precision product and Q-aligned bias, both sign-extended
    prod     = P_W'($signed(x_data)) * P_W'($signed(w_data));
    bias_ext = ACC_W'($signed(b_data)) <<< FRAC_W;

    // Floor shift back to output scale, then saturate to DATA_W
    shifted = acc >>> FRAC_W;
    hi      = shifted[ACC_W-1:DATA_W-1];
    if (hi == '0 || hi == '1) begin
      res = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end
`ifdef RELU_EN
    if (res[DATA_W-1]) begin
      res = '0;
    end
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = LOAD;
          j_n      = '0;
          x_addr_n = '0;
          w_addr_n = '0;
          b_addr_n = '0;
        end
      end
      LOAD: begin
        state_n = MAC;
        k_n     = '0;
        if (N_IN > 1) begin
          x_addr_n = x_addr + XA_W'(1);
          w_addr_n = w_addr + WA_W'(1);
        end
      end
      MAC: begin
        if (k == '0) begin
          acc_n = bias_ext + ACC_W'(prod);
        end else begin
          acc_n = acc + ACC_W'(prod);
        end
        if (k == XA_W'(N_IN - 1)) begin
          state_n = WB;
        end else begin
          k_n = k + XA_W'(1);
          if ((32'(k) + 32'd2) < N_IN) begin
            x_addr_n = x_addr + XA_W'(1);
            w_addr_n = w_addr + WA_W'(1);
          end
        end
      end
      WB: begin
        y_valid_n = 1'b1;
        y_idx_n   = j;
        y_data_n  = res;
        if (j == '0 || res > cand_val) begin
          cand_idx_n = j;
          cand_val_n = res;
        end
        if (j == BA_W'(N_OUT - 1)) begin
          state_n      = DONE;
          done_n       = 1'b1;
          classified_n = cand_idx_n;
          max_score_n  = cand_val_n;
        end else begin
          // w_addr already sits on the last weight of neuron j
          state_n  = LOAD;
          j_n      = j + BA_W'(1);
          b_addr_n = j + BA_W'(1);
          x_addr_n = '0;
          w_addr_n = w_addr + WA_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == LOAD) || (state_n == MAC) || (state_n == WB);
  end

endmodule

// File: doc/fc_seq_classifier.md
Name: fc_seq_classifier

Overview:
- Time-multiplexed fully-connected layer with an integrated argmax classifier. It is the parametrised successor of the fixed 120->84->10 dense path.
- Per job, it computes N_OUT neurons, each as bias plus the dot product of N_IN inputs with that neuron's weights. It uses one signed MAC that reads X, W and B from external synchronous RAMs.
- Each neuron result is streamed out, and the index of the largest result is reported.
- Chains as one stage of the dense stack; the final stage drives the class decision.

Parameters:
- DATA_W, 16, signed fixed-point width of x, w, b and y.
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- N_IN, 120, inputs per neuron.
- N_OUT, 10, neurons (classes).
- ACC_W, 40, accumulator width; must be >= 2*DATA_W+clog2(N_IN)+1.

Ports:
- clk  in  1  rising-edge clock.
- RST  in  1  synchronous active-low reset.
- start  in  1  job request, sampled only in IDLE.
- x_addr  out  clog2(N_IN)  input RAM read address.
- x_data  in  DATA_W  input RAM data, 1-cycle read latency.
- w_addr  out  clog2(N_IN*N_OUT)  weight RAM address, neuron-major (j*N_IN+k).
- w_data  in  DATA_W  weight RAM data, 1-cycle latency.
- b_addr  out  clog2(N_OUT)  bias RAM address.
- b_data  in  DATA_W  bias RAM data, 1-cycle latency.
- busy  out  1  high from LOAD of neuron 0 through last WB.
- y_valid  out  1  one-cycle strobe per neuron result.
- y_idx  out  clog2(N_OUT)  neuron index of y_data.
- y_data  out  DATA_W  neuron result.
- done  out  1  one-cycle pulse, job complete.
- classified  out  clog2(N_OUT)  argmax index; held until the next done.
- max_score  out  DATA_W  value at classified; held.

Behaviour:
- Reset (RST=0 at a clk edge):
  - FSM goes to IDLE.
  - busy, y_valid and done are 0; y_idx, y_data, classified, max_score and all addresses are 0.
  - Reset takes effect mid-job: the job is abandoned and produces no done and no further y_valid.
- FSM states: IDLE, LOAD, MAC, WB, DONE.
- IDLE:
  - start=1 in cycle T moves to LOAD (neuron j=0) in cycle T+1.
  - start=0 stays in IDLE.
- LOAD (1 cycle):
  - Drive b_addr=j, x_addr=0, w_addr=j*N_IN.
  - Next state is MAC with k=0.
- MAC (N_IN cycles, k=0..N_IN-1):
  - Data for element k arrives in this cycle.
  - At k=0: acc = sext(b_data)<<FRAC_W + x_data*w_data.
  - At k>0: acc += x_data*w_data.
  - Products are full signed 2*DATA_W and sign-extended to ACC_W. Accumulator overflow beyond ACC_W wraps (a parameter-sizing error, not handled).
  - While k<N_IN-1, issue x_addr=k+1 and w_addr=j*N_IN+k+1.
  - After k=N_IN-1, go to WB.
- WB (1 cycle):
  - r = acc >>> FRAC_W (arithmetic shift, floor), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register y_data=r and y_idx=j; y_valid=1 in the cycle after WB.
  - Argmax uses a signed compare:
    - j=0: candidate is (0, r) unconditionally.
    - j>0: replace the candidate only if r > candidate (strict), so ties keep the lowest index.
  - If j<N_OUT-1, increment j and go to LOAD; otherwise go to DONE.
- DONE (1 cycle):
  - classified and max_score update from the candidate; done=1 (registered, visible in this cycle).
  - Next state is IDLE.
- Timing:
  - Per-neuron period is N_IN+2 cycles.
  - start sampled in cycle T gives done in cycle T+N_OUT*(N_IN+2)+1. Defaults: T+1221.
- start outside IDLE (including the DONE cycle) is ignored and not queued.
- Input RAM contents must be stable while busy=1; the block does not latch X.

Optional Feature:
- Macro RELU_EN.
- Defined: in WB, r = max(r, 0) after saturation. The ReLU value is used for y_data, argmax and max_score. All-nonpositive neurons give classified=0, max_score=0.
- Undefined: no activation; outputs are the raw saturated results.

Test Plan:
All scenarios use N_IN=4, N_OUT=3, FRAC_W=8, DATA_W=16.
1. Basic job:
   - Stimulus: x=[256,256,256,256]; w0=all 64, b0=0; w1=all 128, b1=0; w2=all 0, b2=-256; start at T.
   - Response: y_valid at T+7,T+13,T+19 with y=256,512,-256; done at T+19; classified=1; max_score=512; busy low at T+19.
2. Tie:
   - Stimulus: set w2=all 128, b2=0 (y2=512 = y1).
   - Response: classified=1 (lowest index kept); max_score=512.
3. Saturation:
   - Stimulus: x=all 0x7FFF, w0=all 0x7FFF; w1=all 0x8000 with x=0x7FFF.
   - Response: y0=0x7FFF, y1=0x8000; no wrap.
4. Negative/ReLU:
   - Stimulus: results -512,-256,-768.
   - Response without RELU_EN: classified=1, max_score=-256. With RELU_EN: y=0,0,0, classified=0, max_score=0.
5. Reset mid-job:
   - Stimulus: RST=0 at T+8 for 1 cycle.
   - Response: from T+9, busy=0, classified=0, max_score=0, no done or y_valid. A new start repeats scenario 1 results exactly.
6. Start handling:
   - Stimulus: start held high for 30 cycles.
   - Response: job 1 done at T+19, job 2 starts at T+20 (start sampled in IDLE), second done at T+39. Pulses mid-job start nothing extra.
